// File: rtl/mc_controller_pkg.sv
// Shared definitions for the multicycle MIPS controller: field widths, opcode/funct
// constants, FSM state encodings, ALU op codes and the per-state control bundle.
package mc_controller_pkg;

    localparam int unsigned OP_W      = 6;
    localparam int unsigned FUNCT_W   = 6;
    localparam int unsigned ALUCTRL_W = 3;
    localparam int unsigned ALUOP_W   = 2;
    localparam int unsigned STATE_W   = 4;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [ALUCTRL_W-1:0] ALUC_ADD = 3'b010;
    localparam logic [ALUCTRL_W-1:0] ALUC_SUB = 3'b110;
    localparam logic [ALUCTRL_W-1:0] ALUC_AND = 3'b000;
    localparam logic [ALUCTRL_W-1:0] ALUC_OR  = 3'b001;
    localparam logic [ALUCTRL_W-1:0] ALUC_SLT = 3'b111;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    // Raw per-state controls before reset gating and the branch/zero merge.
    typedef struct packed {
        logic               pcwrite;
        logic               branch;
        logic               irwrite;
        logic               regwrite;
        logic               memwrite;
        logic               alusrca;
        logic [1:0]         alusrcb;
        logic               iord;
        logic               memtoreg;
        logic               regdst;
        logic [1:0]         pcsrc;
        logic [ALUOP_W-1:0] aluop;
    } ctrl_t;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the FSM's aluop class and the R-type funct field to the ALU control code.
module mc_aludec
    import mc_controller_pkg::*;
(
    input  logic [ALUOP_W-1:0]   aluop,
    input  logic [FUNCT_W-1:0]   funct,
    output logic [ALUCTRL_W-1:0] alucontrol
);

    always_comb begin
        alucontrol = ALUC_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALUC_ADD;
            ALUOP_SUB: alucontrol = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALUC_ADD;
                    FN_SUB:  alucontrol = ALUC_SUB;
                    FN_AND:  alucontrol = ALUC_AND;
                    FN_OR:   alucontrol = ALUC_OR;
                    FN_SLT:  alucontrol = ALUC_SLT;
                    default: alucontrol = ALUC_ADD;
                endcase
            end
            default: alucontrol = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore sequencing FSM plus ALU decoder. Outputs decode
// the current state combinationally so each enable lines up with its datapath cycle.
module mc_controller
    import mc_controller_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [OP_W-1:0]      op,
    input  logic [FUNCT_W-1:0]   funct,
    input  logic                 zero,
    output logic                 pcen,
    output logic                 memwrite,
    output logic                 irwrite,
    output logic                 regwrite,
    output logic                 alusrca,
    output logic [1:0]           alusrcb,
    output logic                 iord,
    output logic                 memtoreg,
    output logic                 regdst,
    output logic [1:0]           pcsrc,
    output logic [ALUCTRL_W-1:0] alucontrol
);

    state_t state;
    state_t state_next;
    ctrl_t  ctrl;

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    // Next-state; unused encodings and unknown opcodes fall back to FETCH.
    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_RTYPEEX;
                    OP_BEQ:       state_next = S_BEQEX;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JEX;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR:  state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_next = S_MEMWB;
            S_RTYPEEX: state_next = S_ALUWB;
            S_ADDIEX:  state_next = S_ADDIWB;
            default:   state_next = S_FETCH;
        endcase
    end

    // Per-state control decode; anything not named stays 0.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.irwrite = 1'b1;
                ctrl.pcwrite = 1'b1;
                ctrl.alusrcb = 2'b01;
            end
            S_DECODE: ctrl.alusrcb = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b10;
            end
            S_MEMRD: ctrl.iord = 1'b1;
            S_MEMWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
            end
            S_BEQEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.pcsrc   = 2'b01;
                ctrl.branch  = 1'b1;
            end
            S_ADDIWB: ctrl.regwrite = 1'b1;
            S_JEX: begin
                ctrl.pcsrc   = 2'b10;
                ctrl.pcwrite = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    // Architectural write enables are suppressed during reset so nothing half-completes.
    assign pcen     = ~reset & (ctrl.pcwrite | (ctrl.branch & zero));
    assign memwrite = ~reset & ctrl.memwrite;
    assign irwrite  = ~reset & ctrl.irwrite;
    assign regwrite = ~reset & ctrl.regwrite;
    assign alusrca  = ctrl.alusrca;
    assign alusrcb  = ctrl.alusrcb;
    assign iord     = ctrl.iord;
    assign memtoreg = ctrl.memtoreg;
    assign regdst   = ctrl.regdst;
    assign pcsrc    = ctrl.pcsrc;

    mc_aludec u_aludec (
        .aluop      (ctrl.aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule
